// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the RV32I register file: round-robin arbitration of two
// writeback requesters plus a post-reset / on-demand clear walk of x1..x31.
module regfile_wr_arbiter #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_rd,
    input  logic [XLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_rd,
    input  logic [XLEN-1:0] req1_data,
    input  logic            init_start,
    output logic            init_busy,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wrs3
);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, nxt_state;
    logic [AW-1:0]   cnt, nxt_cnt;
    logic            last_grant, nxt_last_grant;
    logic            nxt_we;
    logic [AW-1:0]   nxt_rd;
    logic [XLEN-1:0] nxt_wrs3;

    logic            gnt_vld;
    logic            gnt_sel;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;

    assign init_busy = (state == INIT);

    // Grant is purely combinational; init_start blocks it so no write races the restart.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        if (state == RUN && !init_start) begin
            if (req0_valid && req1_valid) begin
                gnt_vld = 1'b1;
                gnt_sel = ~last_grant;
            end else if (req0_valid) begin
                gnt_vld = 1'b1;
                gnt_sel = 1'b0;
            end else if (req1_valid) begin
                gnt_vld = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_vld && !gnt_sel;
    assign req1_ready = gnt_vld &&  gnt_sel;
    assign gnt_rd     = gnt_sel ? req1_rd   : req0_rd;
    assign gnt_data   = gnt_sel ? req1_data : req0_data;

    always_comb begin
        nxt_state      = state;
        nxt_cnt        = cnt;
        nxt_last_grant = last_grant;
        nxt_we         = 1'b0;
        nxt_rd         = rf_rd;
        nxt_wrs3       = rf_wrs3;
        case (state)
            INIT: begin
                nxt_we   = 1'b1;
                nxt_rd   = cnt;
                nxt_wrs3 = '0;
                nxt_cnt  = cnt + 1'b1;
                if (cnt == AW'(NREGS - 1))
                    nxt_state = RUN;
            end
            RUN: begin
                if (init_start) begin
                    nxt_state = INIT;
                    nxt_cnt   = AW'(1);
                end else if (gnt_vld) begin
                    // x0 writes still handshake but never reach the file
                    nxt_we         = (gnt_rd != '0);
                    nxt_rd         = gnt_rd;
                    nxt_wrs3       = gnt_data;
                    nxt_last_grant = gnt_sel;
                end
            end
            default: nxt_state = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            cnt        <= AW'(1);
            last_grant <= 1'b1;
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wrs3    <= '0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            last_grant <= nxt_last_grant;
            rf_we      <= nxt_we;
            rf_rd      <= nxt_rd;
            rf_wrs3    <= nxt_wrs3;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus random traffic
// checked against a behavioural arbiter/regfile model.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        init_start, init_busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wrs3;

    int npass = 0;
    int ntot  = 0;

    bit          mlg;          // model: requester served most recently
    logic [4:0]  erd;          // model: value held on rf_rd
    logic [31:0] edata;        // model: value held on rf_wrs3
    logic [31:0] mreg [32];    // model register contents
    logic [31:0] shadow [32];  // regfile fed by the DUT write port

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
        .init_start(init_start), .init_busy(init_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wrs3(rf_wrs3)
    );

    always @(posedge clk)
        if (rf_we) shadow[rf_rd] <= rf_wrs3;

    // Who is served: the lone requester, or the one not served last time; nobody on init_start.
    function automatic int model_grant(bit v0, bit v1, bit lg, bit ini);
        if (ini) return -1;
        if (v0 && v1) return lg ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b0; init_start = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd4; req0_data = 32'h1;
        req1_valid = 1'b1; req1_rd = 5'd5; req1_data = 32'h2;
        mlg = 1'b1; erd = '0; edata = '0;
        #1;
        ntot++;
        if ({init_busy, rf_we, rf_rd, rf_wrs3, req0_ready, req1_ready} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset_async: got busy=%b we=%b rd=%0d d=%h rdy=%b%b want 1 0 0 0 00",
                     init_busy, rf_we, rf_rd, rf_wrs3, req0_ready, req1_ready);
        else npass++;
        @(posedge clk); #1;
        ntot++;
        if ({init_busy, rf_we, rf_rd, rf_wrs3, req0_ready, req1_ready} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset_held: got busy=%b we=%b rd=%0d d=%h rdy=%b%b want 1 0 0 0 00",
                     init_busy, rf_we, rf_rd, rf_wrs3, req0_ready, req1_ready);
        else npass++;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_init_walk();
        logic [4:0] ri;
        @(negedge clk) reset = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk); #1;
            ri = i[4:0];
            ntot++;
            if ({rf_we, rf_rd, rf_wrs3, init_busy} !== {1'b1, ri, 32'd0, 1'(i < 31)})
                $display("FAIL init_walk[%0d]: got we=%b rd=%0d d=%h busy=%b want 1 %0d 0 %b",
                         i, rf_we, rf_rd, rf_wrs3, init_busy, ri, 1'(i < 31));
            else npass++;
        end
        erd = 5'd31; edata = '0;
        for (int r = 0; r < 32; r++) mreg[r] = '0;
        @(posedge clk); #1;
        ntot++;
        if (rf_we !== 1'b0) $display("FAIL init_idle_after: got we=%b want 0", rf_we);
        else npass++;
        begin
            int bad = 0;
            for (int r = 1; r < 32; r++) if (shadow[r] !== 32'd0) bad++;
            ntot++;
            if (bad != 0) $display("FAIL init_clear_regs: got %0d nonzero regs want 0", bad);
            else npass++;
        end
    endtask

    task automatic test_alternate();
        int g;
        @(negedge clk);
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hA;
        req1_valid = 1'b1; req1_rd = 5'd6; req1_data = 32'hB;
        for (int c = 0; c < 4; c++) begin
            #1;
            g = model_grant(1'b1, 1'b1, mlg, 1'b0);
            ntot++;
            if ({req0_ready, req1_ready} !== {1'(g == 0), 1'(g == 1)})
                $display("FAIL alt_ready[%0d]: got %b%b want %b%b", c, req0_ready, req1_ready,
                         1'(g == 0), 1'(g == 1));
            else npass++;
            @(posedge clk); #1;
            erd   = (g == 1) ? 5'd6 : 5'd5;
            edata = (g == 1) ? 32'hB : 32'hA;
            mreg[erd] = edata;
            mlg = (g == 1);
            ntot++;
            if ({rf_we, rf_rd, rf_wrs3} !== {1'b1, erd, edata})
                $display("FAIL alt_write[%0d]: got we=%b rd=%0d d=%h want 1 %0d %h",
                         c, rf_we, rf_rd, rf_wrs3, erd, edata);
            else npass++;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'd16;
        #1;
        ntot++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
        else npass++;
        @(posedge clk); #1;
        ntot++;
        if ({rf_we, rf_rd, rf_wrs3} !== {1'b1, 5'd3, 32'd16})
            $display("FAIL single_write: got we=%b rd=%0d d=%h want 1 3 10", rf_we, rf_rd, rf_wrs3);
        else npass++;
        mlg = 1'b0; erd = 5'd3; edata = 32'd16; mreg[3] = 32'd16;
        @(negedge clk) req0_valid = 1'b0;
        @(posedge clk); #1;
        ntot++;
        if ({rf_we, shadow[3]} !== {1'b0, 32'd16})
            $display("FAIL single_readback: got we=%b x3=%h want 0 10", rf_we, shadow[3]);
        else npass++;
    endtask

    task automatic test_x0();
        @(negedge clk);
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hFFFF_FFFF;
        #1;
        ntot++;
        if ({req0_ready, req1_ready} !== 2'b01)
            $display("FAIL x0_ready: got %b%b want 01", req0_ready, req1_ready);
        else npass++;
        @(posedge clk); #1;
        ntot++;
        if ({rf_we, rf_rd} !== {1'b0, 5'd0})
            $display("FAIL x0_dropped: got we=%b rd=%0d want 0 0", rf_we, rf_rd);
        else npass++;
        mlg = 1'b1; erd = 5'd0; edata = 32'hFFFF_FFFF;
        @(negedge clk) req1_valid = 1'b0;
        @(posedge clk); #1;
        ntot++;
        if (shadow[0] !== 32'd0) $display("FAIL x0_readback: got %h want 0", shadow[0]);
        else npass++;
    endtask

    task automatic test_init_start();
        logic [4:0] ri;
        @(negedge clk);
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77; init_start = 1'b1;
        #1;
        ntot++;
        if ({req0_ready, req1_ready, init_busy} !== 3'b000)
            $display("FAIL istart_block: got rdy=%b%b busy=%b want 00 0", req0_ready, req1_ready, init_busy);
        else npass++;
        @(posedge clk); #1;
        ntot++;
        if ({rf_we, rf_rd, rf_wrs3, init_busy} !== {1'b0, erd, edata, 1'b1})
            $display("FAIL istart_enter: got we=%b rd=%0d d=%h busy=%b want 0 %0d %h 1",
                     rf_we, rf_rd, rf_wrs3, init_busy, erd, edata);
        else npass++;
        @(negedge clk) init_start = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk); #1;
            ri = i[4:0];
            ntot++;
            if ({rf_we, rf_rd, rf_wrs3, init_busy} !== {1'b1, ri, 32'd0, 1'(i < 31)})
                $display("FAIL istart_walk[%0d]: got we=%b rd=%0d d=%h busy=%b", i, rf_we, rf_rd, rf_wrs3, init_busy);
            else npass++;
            if (i < 31) begin
                ntot++;
                if ({req0_ready, req1_ready} !== 2'b00)
                    $display("FAIL istart_noready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
                else npass++;
            end
            // a restart request during the walk must be ignored
            if (i == 5) init_start = 1'b1;
            if (i == 6) init_start = 1'b0;
        end
        for (int r = 0; r < 32; r++) mreg[r] = '0;
        ntot++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL istart_first_run: got %b%b want 10", req0_ready, req1_ready);
        else npass++;
        @(posedge clk); #1;
        ntot++;
        if ({rf_we, rf_rd, rf_wrs3} !== {1'b1, 5'd7, 32'h77})
            $display("FAIL istart_write: got we=%b rd=%0d d=%h want 1 7 77", rf_we, rf_rd, rf_wrs3);
        else npass++;
        mlg = 1'b0; erd = 5'd7; edata = 32'h77; mreg[7] = 32'h77;
        @(negedge clk) req0_valid = 1'b0;
    endtask

    task automatic test_random();
        int g;
        int bad = 0;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            // a requester keeps its write presented until it is accepted
            if (!req0_valid) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_rd = 5'($urandom_range(0, 7)); req0_data = $urandom;
            end
            if (!req1_valid) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_rd = 5'($urandom_range(0, 7)); req1_data = $urandom;
            end
            #1;
            g = model_grant(req0_valid, req1_valid, mlg, 1'b0);
            if ({req0_ready, req1_ready} !== {1'(g == 0), 1'(g == 1)}) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got %b%b want %b%b", c, req0_ready, req1_ready,
                         1'(g == 0), 1'(g == 1));
            end
            wrd  = (g == 1) ? req1_rd : req0_rd;
            wdat = (g == 1) ? req1_data : req0_data;
            @(posedge clk); #1;
            if (g >= 0) begin
                erd = wrd; edata = wdat; mlg = (g == 1);
                if (wrd != 0) mreg[wrd] = wdat;
                if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
            end
            if ({rf_we, rf_rd, rf_wrs3} !== {1'(g >= 0 && wrd != 0), erd, edata}) begin
                bad++;
                $display("FAIL rand_write[%0d]: got we=%b rd=%0d d=%h want %b %0d %h", c,
                         rf_we, rf_rd, rf_wrs3, 1'(g >= 0 && wrd != 0), erd, edata);
            end
        end
        ntot++;
        if (bad != 0) $display("FAIL rand_traffic: got %0d bad cycles want 0", bad);
        else npass++;
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        for (int r = 0; r < 8; r++) begin
            ntot++;
            if (shadow[r] !== mreg[r]) $display("FAIL rand_reg[x%0d]: got %h want %h", r, shadow[r], mreg[r]);
            else npass++;
        end
    endtask

    task automatic test_reset_mid_init();
        @(negedge clk) init_start = 1'b1;
        @(negedge clk) init_start = 1'b0;
        for (int i = 1; i <= 10; i++) @(posedge clk);
        #1;
        ntot++;
        if ({rf_we, rf_rd} !== {1'b1, 5'd10})
            $display("FAIL mid_init_pos: got we=%b rd=%0d want 1 10", rf_we, rf_rd);
        else npass++;
        #1 reset = 1'b0;
        #1;
        ntot++;
        if ({rf_we, rf_rd, rf_wrs3, init_busy} !== {1'b1 ^ 1'b1, 5'd0, 32'd0, 1'b1})
            $display("FAIL mid_init_abort: got we=%b rd=%0d d=%h busy=%b want 0 0 0 1",
                     rf_we, rf_rd, rf_wrs3, init_busy);
        else npass++;
        mlg = 1'b1;
        test_init_walk();
        @(negedge clk);
        req0_valid = 1'b1; req0_rd = 5'd9;  req0_data = 32'h99;
        req1_valid = 1'b1; req1_rd = 5'd10; req1_data = 32'hAA;
        #1;
        ntot++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL mid_init_lastgrant: got %b%b want 10", req0_ready, req1_ready);
        else npass++;
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) shadow[r] = 32'hDEAD_BEEF;
        shadow[0] = 32'd0;
        test_reset();
        test_init_walk();
        test_alternate();
        test_single();
        test_x0();
        test_init_start();
        test_random();
        test_reset_mid_init();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Write-port controller for the RV32I register file (regfile). It shares the file's single write port (rd/wrs3/we) between two writeback requesters, req0 (execute) and req1 (memory load), using valid/ready handshakes and round-robin priority. It also runs a clear sequence that writes zero to x1..x31 after reset, or on request.

Parameters:
XLEN, 32, data width of write data.
NREGS, 32, number of architectural registers; the clear walk covers 1..NREGS-1.
AW, 5, register index width; must satisfy 2**AW == NREGS.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; low asserts.
req0_valid  input  1  requester 0 has a write pending.
req0_ready  output  1  requester 0 write accepted this cycle.
req0_rd  input  AW  requester 0 destination register.
req0_data  input  XLEN  requester 0 write data.
req1_valid  input  1  requester 1 has a write pending.
req1_ready  output  1  requester 1 write accepted this cycle.
req1_rd  input  AW  requester 1 destination register.
req1_data  input  XLEN  requester 1 write data.
init_start  input  1  restart the clear sequence; sampled in RUN only.
init_busy  output  1  high while the clear sequence is active.
rf_we  output  1  to regfile we.
rf_rd  output  AW  to regfile rd.
rf_wrs3  output  XLEN  to regfile wrs3.

Behaviour:
- States: INIT, RUN. A 1-bit last_grant register holds 0 or 1. An AW-bit counter cnt drives the clear walk.
- Reset (low, asynchronous): state=INIT, cnt=1, last_grant=1, rf_we=0, rf_rd=0, rf_wrs3=0. init_busy is 1 during and after reset until INIT completes.
- init_busy = (state==INIT), combinational.
- INIT, each edge:
  - rf_we<=1, rf_rd<=cnt, rf_wrs3<=0, cnt<=cnt+1.
  - When cnt==NREGS-1, state<=RUN.
  - Result: exactly 31 consecutive write cycles, rd 1..31. The first write is registered on the first edge after reset deasserts.
- INIT: req0_ready and req1_ready are held 0.
- RUN arbitration (combinational grant; ready is never asserted without its valid):
  - Only req0_valid high: grant 0.
  - Only req1_valid high: grant 1.
  - Both high: grant the requester not equal to last_grant.
  - Neither high: no grant.
  - init_start high: no grant, regardless of valids.
- reqN_ready = (grant==N). A handshake completes on an edge where valid and ready are both high. Requesters hold rd and data stable until ready.
- RUN, edge with a grant:
  - rf_rd<=granted rd, rf_wrs3<=granted data, last_grant<=N.
  - rf_we<=1 only if granted rd!=0. A write to x0 still completes its handshake but is dropped (rf_we<=0).
- RUN, edge without a grant: rf_we<=0. rf_rd and rf_wrs3 hold their values.
- Latency: the write appears on rf_* exactly 1 cycle after the accepting edge. Throughput is one write per cycle.
- Simultaneous same rd from both requesters: serialized in grant order, so the later grant's data is the final register content.
- init_start in RUN: next edge sets state<=INIT, cnt<=1, rf_we<=0. The clear walk starts the edge after. init_start is ignored while in INIT.
- Reset asserted mid-INIT or mid-RUN: immediate return to the reset state. Any write being presented on rf_* is abandoned (rf_we=0 asynchronously). The clear walk restarts from x1.
- cnt never wraps into 0 during INIT: the transition to RUN happens at NREGS-1.

Test Plan:
1. Release reset, no requests -> rf_we=1 for 31 consecutive cycles with rf_rd=1..31 and rf_wrs3=0; init_busy then falls; a regfile read of x1..x31 returns 0.
2. In RUN, req0 only: rd=3, data=16 -> req0_ready=1 same cycle; next cycle rf_we=1, rf_rd=3, rf_wrs3=16; regfile read of x3 returns 16.
3. Both valid for 4 cycles: req0 rd=5 data=0xA, req1 rd=6 data=0xB, last_grant=1 after reset -> grants alternate 0,1,0,1; ready is never high for both in the same cycle.
4. req1 rd=0 data=0xFFFFFFFF -> req1_ready=1; next cycle rf_we=0; x0 reads 0.
5. init_start pulsed while req0_valid=1 -> req0_ready=0 that cycle; 31-cycle clear follows; req0 is granted on the first RUN cycle after.
6. Reset pulsed low during INIT at rd=10 -> rf_we=0 immediately; after release the walk restarts at rd=1.
